fft_out_serializer: RTL and testbench
=====================================

FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 12, SHALL set the signed width of each real/imaginary component (the FFT output width).
REQ-002 Parameter LANES, default 4, SHALL set the complex samples per output beat; only 4 is supported, with a frame of 16 samples in 4 beats.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_async  input  1  SHALL be the asynchronous active-high reset.
REQ-006 i_valid  input  1  SHALL be a one-cycle pulse indicating i_data holds a complete 16-sample frame.
REQ-007 i_data  input  [16][2] x DATA_WIDTH signed  SHALL carry the frame; index [k][0] is real, [k][1] is imaginary.
REQ-008 o_valid  output  1  SHALL indicate o_data holds a valid beat.
REQ-009 o_data  output  [4][2] x DATA_WIDTH signed  SHALL carry samples beat*4+lane, lane 0..3.
REQ-010 o_sop / o_eop  output  1 each  SHALL flag beat 0 and beat 3 of a frame, qualified by o_valid.
REQ-011 i_ready  input  1  SHALL be the downstream ready.
REQ-012 o_overflow  output  1  SHALL be a sticky dropped-frame flag.
REQ-013 i_clr_ovf  input  1  SHALL clear o_overflow.
REQ-014 o_frame_cnt  output  8  SHALL count frames fully emitted, modulo 256.

Function
REQ-015 Two frame banks (ping-pong) SHALL be kept, with write pointer wr_sel, read pointer rd_sel, occupancy cnt in 0..2, and beat counter beat in 0..3.
REQ-016 Capture: on i_valid with a free bank, all 16 samples SHALL be written into bank wr_sel at that edge, wr_sel SHALL toggle, and cnt SHALL increment.
REQ-017 A bank freed at the same edge (last beat accepted) SHALL count as free, so capture is allowed when cnt==2 and the eop handshake occurs that cycle.
REQ-018 When i_valid arrives with no free bank, the frame SHALL be dropped, the banks SHALL be untouched, and o_overflow SHALL be set.
REQ-019 o_valid SHALL equal (cnt>0), so the first beat is presented in the cycle after the capture edge (latency 1 cycle).
REQ-020 A beat SHALL transfer on o_valid && i_ready; beat SHALL then increment.
REQ-021 On transfer of beat 3, the bank SHALL be freed, rd_sel SHALL toggle, beat SHALL return to 0, cnt SHALL decrement, and o_frame_cnt SHALL increment with wrap 255->0.
REQ-022 On a simultaneous capture and free, cnt SHALL be unchanged.
REQ-023 While o_valid && !i_ready, o_data, o_sop and o_eop SHALL hold stable.
REQ-024 o_data SHALL drive all zeros while o_valid is low.
REQ-025 Values SHALL pass bit-exact; no scaling, rounding or reordering.
REQ-026 If set and i_clr_ovf occur in the same cycle, set SHALL win.

Reset
REQ-027 rst_async SHALL force immediately: o_valid=0, o_sop=0, o_eop=0, o_data=0, o_overflow=0, o_frame_cnt=0, cnt=0, beat=0, wr_sel=0, rst_sel=0 (rd_sel=0).
REQ-028 Bank contents SHALL need no reset.
REQ-029 Reset asserted mid-frame SHALL discard all buffered frames, with no partial beats emitted after release.

Structure
REQ-030 Package fft_pkg SHALL hold FFT_N=16, LANES=4, OUTPUT_WIDTH default 12, and a complex sample typedef shared with the FFT front end.
REQ-031 One sub-module, fft_frame_bank, SHALL implement a single 16x2 register bank with write-enable and 4-sample beat read mux; it SHALL be instantiated twice.

Verification
REQ-032 Single frame with samples k = (k, -k), i_ready=1 -> o_valid for exactly 4 consecutive cycles starting 1 cycle after i_valid; beat b = samples 4b..4b+3; sop on beat 0, eop on beat 3; o_frame_cnt=1.
REQ-033 i_ready toggled 1,0,0,1,... during a frame -> o_data held stable while stalled; all 4 beats delivered in order, none lost or duplicated.
REQ-034 Three frames A, B, C on consecutive cycles with i_ready=0 -> A and B buffered, C dropped, o_overflow=1; after releasing i_ready, A then B emitted; pulsing i_clr_ovf clears the flag.
REQ-035 cnt==2 with i_valid coincident with an accepted eop beat -> new frame captured, o_overflow remains 0.
REQ-036 Extreme values 0x800/0x7FF in every lane -> emitted bit-exact; 256 frames -> o_frame_cnt wraps to 0.
REQ-037 rst_async asserted during beat 2 -> o_valid drops immediately and nothing is emitted after release until a new i_valid.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: constants and the complex sample type shared between the FFT
// front end and the output serializer.
//   FFT_N        : samples per FFT frame
//   LANES        : complex samples per serialized output beat
//   BEATS        : beats per frame
//   OUTPUT_WIDTH : default signed width of each real/imaginary component
package fft_pkg;

    localparam int FFT_N        = 16;
    localparam int LANES        = 4;
    localparam int BEATS        = FFT_N / LANES;
    localparam int OUTPUT_WIDTH = 12;

    typedef struct packed {
        logic signed [OUTPUT_WIDTH-1:0] im;
        logic signed [OUTPUT_WIDTH-1:0] re;
    } cplx_t;

endpackage

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: one 16-sample complex frame buffer. The whole frame is
// written in a single cycle; reads present one 4-sample beat selected by beat.
// Contents carry no reset, since a bank is only read after it has been written.
//   clk      : clock
//   we       : write enable, loads all of wr_data
//   wr_data  : [16][2] signed samples, [k][0]=real, [k][1]=imaginary
//   beat     : beat index 0..3 for the read mux
//   rd_data  : [4][2] samples beat*4 .. beat*4+3
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = OUTPUT_WIDTH
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic signed [DATA_WIDTH-1:0] wr_data [FFT_N][2],
    input  logic        [1:0]            beat,
    output logic signed [DATA_WIDTH-1:0] rd_data [LANES][2]
);

    logic signed [DATA_WIDTH-1:0] mem [FFT_N][2];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < FFT_N; k++) begin
                for (int c = 0; c < 2; c++) begin
                    mem[k][c] <= wr_data[k][c];
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            for (int c = 0; c < 2; c++) begin
                rd_data[l][c] = mem[{beat, 2'(l)}][c];
            end
        end
    end

endmodule

// File: rtl/fft_out_serializer.sv
// fft_out_serializer: captures whole 16-sample FFT frames into a ping-pong
// pair of banks and streams each frame out as 4 beats of 4 complex samples
// under a valid/ready handshake.
//   clk          : clock, rising edge
//   rst_async    : asynchronous active-high reset
//   i_valid      : one-cycle pulse, i_data holds a full frame
//   i_data       : [16][2] signed samples, [k][0]=real, [k][1]=imaginary
//   i_ready      : downstream ready
//   i_clr_ovf    : clears o_overflow (a simultaneous drop wins)
//   o_valid      : o_data holds a beat
//   o_data       : [4][2] samples beat*4+lane, zero while o_valid is low
//   o_sop/o_eop  : first / last beat of a frame
//   o_overflow   : sticky, a frame arrived with both banks full
//   o_frame_cnt  : frames fully emitted, modulo 256
module fft_out_serializer #(
    parameter int DATA_WIDTH = fft_pkg::OUTPUT_WIDTH,
    parameter int LANES      = fft_pkg::LANES
) (
    input  logic                         clk,
    input  logic                         rst_async,
    input  logic                         i_valid,
    input  logic signed [DATA_WIDTH-1:0] i_data [fft_pkg::FFT_N][2],
    input  logic                         i_ready,
    input  logic                         i_clr_ovf,
    output logic                         o_valid,
    output logic signed [DATA_WIDTH-1:0] o_data [LANES][2],
    output logic                         o_sop,
    output logic                         o_eop,
    output logic                         o_overflow,
    output logic        [7:0]            o_frame_cnt
);

    logic       wr_sel;
    logic       rd_sel;
    logic [1:0] cnt;
    logic [1:0] beat;

    logic xfer;
    logic last;
    logic bank_free;
    logic capture;
    logic drop;

    logic signed [DATA_WIDTH-1:0] rd0 [LANES][2];
    logic signed [DATA_WIDTH-1:0] rd1 [LANES][2];

    assign o_valid   = (cnt != 2'd0);
    assign xfer      = o_valid && i_ready;
    assign last      = xfer && (beat == 2'd3);
    // A bank emptied by the eop handshake on this edge may be refilled on
    // the same edge, so a full buffer can still accept a frame.
    assign bank_free = (cnt != 2'd2) || last;
    assign capture   = i_valid && bank_free;
    assign drop      = i_valid && !bank_free;

    assign o_sop = o_valid && (beat == 2'd0);
    assign o_eop = o_valid && (beat == 2'd3);

    fft_frame_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank0 (
        .clk     (clk),
        .we      (capture && !wr_sel),
        .wr_data (i_data),
        .beat    (beat),
        .rd_data (rd0)
    );

    fft_frame_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank1 (
        .clk     (clk),
        .we      (capture && wr_sel),
        .wr_data (i_data),
        .beat    (beat),
        .rd_data (rd1)
    );

    // Control state; bank contents are outside the reset domain.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            cnt         <= 2'd0;
            beat        <= 2'd0;
            o_overflow  <= 1'b0;
            o_frame_cnt <= 8'd0;
        end else begin
            if (capture) begin
                wr_sel <= ~wr_sel;
            end
            if (xfer) begin
                beat <= beat + 2'd1;
            end
            if (last) begin
                rd_sel      <= ~rd_sel;
                o_frame_cnt <= o_frame_cnt + 8'd1;
            end
            unique case ({capture, last})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                o_overflow <= 1'b0;
            end
        end
    end

    // Output beat mux, forced to zero when no beat is presented.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            for (int c = 0; c < 2; c++) begin
                o_data[l][c] = '0;
                if (o_valid) begin
                    o_data[l][c] = rd_sel ? rd1[l][c] : rd0[l][c];
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
module tb_fft_out_serializer;

    localparam int W = 12;

    typedef struct packed {
        logic [95:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic                clk = 1'b0;
    logic                rst_async;
    logic                i_valid;
    logic signed [W-1:0] i_data [16][2];
    logic                i_ready;
    logic                i_clr_ovf;
    logic                o_valid;
    logic signed [W-1:0] o_data [4][2];
    logic                o_sop;
    logic                o_eop;
    logic                o_overflow;
    logic [7:0]          o_frame_cnt;

    int    total = 0;
    int    bad   = 0;
    int    exp_fc = 0;
    int    n_beats = 0;
    beat_t exp_q [$];

    logic [95:0] mon_cur;
    logic [95:0] held;
    logic        held_sop;
    logic        held_eop;
    logic        was_stall = 1'b0;

    fft_out_serializer #(.DATA_WIDTH(W), .LANES(4)) dut (
        .clk         (clk),
        .rst_async   (rst_async),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_ready     (i_ready),
        .i_clr_ovf   (i_clr_ovf),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_sop       (o_sop),
        .o_eop       (o_eop),
        .o_overflow  (o_overflow),
        .o_frame_cnt (o_frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] pack_o();
        logic [95:0] p;
        for (int l = 0; l < 4; l++) begin
            p[l*24 +: 12]      = o_data[l][0];
            p[l*24 + 12 +: 12] = o_data[l][1];
        end
        return p;
    endfunction

    // Output monitor: scoreboard pops, stall stability, idle zeros.
    always @(negedge clk) begin
        if (!rst_async) begin
            mon_cur = pack_o();
            if (!o_valid) begin
                total++;
                if (mon_cur !== 96'd0) begin
                    bad++;
                    $display("FAIL idle_zero: o_data=%h want 0", mon_cur);
                end
            end
            if (was_stall && o_valid) begin
                total++;
                if ({mon_cur, o_sop, o_eop} !== {held, held_sop, held_eop}) begin
                    bad++;
                    $display("FAIL stall_hold: got %h sop=%b eop=%b want %h sop=%b eop=%b",
                             mon_cur, o_sop, o_eop, held, held_sop, held_eop);
                end
            end
            if (o_valid && i_ready) begin
                beat_t e;
                total++;
                n_beats++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_beat: got %h with nothing expected", mon_cur);
                end else begin
                    e = exp_q.pop_front();
                    if ({mon_cur, o_sop, o_eop} !== {e.data, e.sop, e.eop}) begin
                        bad++;
                        $display("FAIL beat_data: got %h sop=%b eop=%b want %h sop=%b eop=%b",
                                 mon_cur, o_sop, o_eop, e.data, e.sop, e.eop);
                    end
                end
            end
            was_stall = o_valid && !i_ready;
            held      = mon_cur;
            held_sop  = o_sop;
            held_eop  = o_eop;
        end else begin
            was_stall = 1'b0;
        end
    end

    // Loads a frame onto i_data, raises i_valid, and optionally queues its beats.
    task automatic drive_frame(input int mode, input int base, input bit push);
        beat_t b;
        for (int k = 0; k < 16; k++) begin
            case (mode)
                1: begin
                    i_data[k][0] = (k % 2 == 0) ? 12'sh800 : 12'sh7FF;
                    i_data[k][1] = (k % 2 == 0) ? 12'sh7FF : 12'sh800;
                end
                2: begin
                    i_data[k][0] = (k % 2 == 0) ? 12'sh7FF : 12'sh800;
                    i_data[k][1] = (k % 2 == 0) ? 12'sh800 : 12'sh7FF;
                end
                default: begin
                    i_data[k][0] = 12'(base + k);
                    i_data[k][1] = 12'(-(base + k));
                end
            endcase
        end
        i_valid = 1'b1;
        if (push) begin
            for (int bt = 0; bt < 4; bt++) begin
                for (int l = 0; l < 4; l++) begin
                    b.data[l*24 +: 12]      = i_data[bt*4 + l][0];
                    b.data[l*24 + 12 +: 12] = i_data[bt*4 + l][1];
                end
                b.sop = (bt == 0);
                b.eop = (bt == 3);
                exp_q.push_back(b);
            end
            exp_fc++;
        end
    endtask

    task automatic send_frame(input int mode, input int base);
        @(posedge clk); #1;
        drive_frame(mode, base, 1'b1);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d beats still pending, want 0", name, exp_q.size());
            exp_q.delete();
        end
        total++;
        if (o_frame_cnt !== 8'(exp_fc)) begin
            bad++;
            $display("FAIL %s_frame_cnt: got %0d want %0d", name, o_frame_cnt, 8'(exp_fc));
        end
    endtask

    task automatic test_reset();
        rst_async = 1'b1;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_clr_ovf = 1'b0;
        for (int k = 0; k < 16; k++) begin
            i_data[k][0] = '0;
            i_data[k][1] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        total++;
        if ({o_valid, o_sop, o_eop, o_overflow} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: valid/sop/eop/ovf=%b want 0000",
                     {o_valid, o_sop, o_eop, o_overflow});
        end
        total++;
        if (o_frame_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_frame_cnt: got %0d want 0", o_frame_cnt);
        end
        total++;
        if (pack_o() !== 96'd0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", pack_o());
        end
        @(posedge clk); #1;
        rst_async = 1'b0;
    endtask

    task automatic test_single();
        logic vld [8];
        i_ready = 1'b1;
        send_frame(0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vld[i] = o_valid;
            if (i == 0) begin
                total++;
                if (o_sop !== 1'b1) begin
                    bad++;
                    $display("FAIL single_sop_first: got %b want 1", o_sop);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (vld[i] !== (i < 4)) begin
                bad++;
                $display("FAIL single_valid_cycle%0d: got %b want %b", i, vld[i], (i < 4));
            end
        end
        drain("single");
    endtask

    task automatic test_stall();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int start = n_beats;
        i_ready = 1'b1;
        send_frame(0, 100);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            i_ready = pat[i % 4];
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        drain("stall");
        total++;
        if (n_beats - start !== 4) begin
            bad++;
            $display("FAIL stall_beat_count: got %0d want 4", n_beats - start);
        end
    endtask

    task automatic test_overflow();
        @(posedge clk); #1;
        i_ready = 1'b0;
        @(posedge clk); #1;
        drive_frame(0, 200, 1'b1);
        @(posedge clk); #1;
        drive_frame(0, 300, 1'b1);
        @(posedge clk); #1;
        drive_frame(0, 400, 1'b0);
        i_clr_ovf = 1'b1;
        @(posedge clk); #1;
        i_valid   = 1'b0;
        i_clr_ovf = 1'b0;
        @(negedge clk);
        total++;
        if (o_overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: got %b want 1", o_overflow);
        end
        total++;
        if ({o_valid, o_sop, pack_o()} !== {1'b1, 1'b1, exp_q[0].data}) begin
            bad++;
            $display("FAIL ovf_head_beat: valid=%b sop=%b data=%h want 1 1 %h",
                     o_valid, o_sop, pack_o(), exp_q[0].data);
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
        drain("overflow");
        total++;
        if (o_overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: got %b want 1", o_overflow);
        end
        i_clr_ovf = 1'b1;
        @(posedge clk); #1;
        i_clr_ovf = 1'b0;
        total++;
        if (o_overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: got %b want 0", o_overflow);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        i_ready = 1'b0;
        drive_frame(0, 500, 1'b1);
        @(posedge clk); #1;
        drive_frame(0, 600, 1'b1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        drive_frame(0, 700, 1'b1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        total++;
        if (o_overflow !== 1'b0) begin
            bad++;
            $display("FAIL b2b_no_ovf: got %b want 0", o_overflow);
        end
        drain("back_to_back");
    endtask

    task automatic test_extreme();
        i_ready = 1'b1;
        send_frame(1, 0);
        send_frame(2, 0);
        drain("extreme");
    endtask

    task automatic test_wrap();
        i_ready = 1'b1;
        while (exp_fc < 255) begin
            @(posedge clk); #1;
            drive_frame(0, int'($urandom_range(0, 4095)), 1'b1);
            @(posedge clk); #1;
            i_valid = 1'b0;
            repeat (2) @(posedge clk);
        end
        drain("wrap255");
        send_frame(0, 42);
        drain("wrap0");
        total++;
        if (o_frame_cnt !== 8'd0) begin
            bad++;
            $display("FAIL wrap_zero: got %0d want 0", o_frame_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        i_ready = 1'b1;
        send_frame(0, 800);
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if ({o_valid, o_sop, o_eop} !== 3'b100) begin
            bad++;
            $display("FAIL rstmid_at_beat2: valid/sop/eop=%b want 100", {o_valid, o_sop, o_eop});
        end
        rst_async = 1'b1;
        #1;
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_valid_drop: got %b want 0", o_valid);
        end
        exp_q.delete();
        exp_fc = 0;
        @(posedge clk); #3;
        rst_async = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_valid) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL rstmid_no_stray: got %0d valid cycles want 0", stray);
        end
        send_frame(0, 900);
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_extreme();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
